// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: requester
// indices, FSM state encoding and fixed port widths.
package regfile_write_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int N_REQ  = 4;

  // Requester index constants (also the mux select values).
  localparam logic [1:0] REQ_ALU  = 2'd0;
  localparam logic [1:0] REQ_FPU  = 2'd1;
  localparam logic [1:0] REQ_LOAD = 2'd2;
  localparam logic [1:0] REQ_MDU  = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // One-hot accept strobe for a requester index.
  function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_mux.sv
// Write-port data and address selectors, driven by the index of the
// requester being granted this cycle.
module mux4to1by32 (
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_d0,
  input  logic [31:0] i_d1,
  input  logic [31:0] i_d2,
  input  logic [31:0] i_d3,
  output logic [31:0] o_y
);

  // Select one of four 32-bit data words.
  always_comb begin
    unique case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

module mux4to1by5 (
  input  logic [1:0] i_sel,
  input  logic [4:0] i_d0,
  input  logic [4:0] i_d1,
  input  logic [4:0] i_d2,
  input  logic [4:0] i_d3,
  output logic [4:0] o_y
);

  // Select one of four 5-bit register addresses.
  always_comb begin
    unique case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/regfile_write_arbiter_pick.sv
// Round-robin priority picker: finds the first valid requester at or after
// the pointer, wrapping 3 -> 0.
module rr_priority_pick (
  input  logic [3:0] i_valid,
  input  logic [1:0] i_ptr,
  output logic       o_hit,
  output logic [1:0] o_idx
);

  // Scan offsets from farthest to nearest so the nearest valid wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise paths
    // with no valid requester would infer a latch.
    o_hit = 1'b0;
    o_idx = i_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (i_valid[i_ptr + 2'(k)]) begin
        o_hit = 1'b1;
        o_idx = i_ptr + 2'(k);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port among four writeback
// requesters (ALU, FPU, load, mult/div) with round-robin arbitration and an
// optional bounded lock for multi-register bursts. Writes leave registered.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [3:0]  req_lock,
  input  logic [4:0]  req_addr0,
  input  logic [4:0]  req_addr1,
  input  logic [4:0]  req_addr2,
  input  logic [4:0]  req_addr3,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  input  logic [31:0] req_data2,
  input  logic [31:0] req_data3,
  output logic [3:0]  req_ready,
  input  logic        wr_stall,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [1:0]  grant_id,
  output logic        locked
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  state_t             r_state;
  logic [1:0]         r_rr_ptr;
  logic [1:0]         r_owner;
  logic [CNT_W-1:0]   r_lock_cnt;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic [1:0]         r_grant_id;

  logic               w_pick_hit;
  logic [1:0]         w_pick_idx;
  logic               w_grant;
  logic [1:0]         w_gidx;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;

  rr_priority_pick u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_hit   (w_pick_hit),
    .o_idx   (w_pick_idx)
  );

  // Grant decision: round-robin in IDLE, owner-only in LOCKED; nothing while
  // stalled or in reset.
  always_comb begin
    w_grant = 1'b0;
    w_gidx  = w_pick_idx;
    if (!reset && !wr_stall) begin
      if (r_state == ST_IDLE) begin
        w_grant = w_pick_hit;
        w_gidx  = w_pick_idx;
      end else begin
        w_grant = req_valid[r_owner];
        w_gidx  = r_owner;
      end
    end
  end

  assign req_ready = w_grant ? onehot4(w_gidx) : 4'b0000;

  mux4to1by5 u_addr_mux (
    .i_sel (w_gidx),
    .i_d0  (req_addr0),
    .i_d1  (req_addr1),
    .i_d2  (req_addr2),
    .i_d3  (req_addr3),
    .o_y   (w_sel_addr)
  );

  mux4to1by32 u_data_mux (
    .i_sel (w_gidx),
    .i_d0  (req_data0),
    .i_d1  (req_data1),
    .i_d2  (req_data2),
    .i_d3  (req_data3),
    .o_y   (w_sel_data)
  );

  // Register the accepted write; writes to $zero are accepted but not enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_grant_id <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_wr_en <= w_grant && (w_sel_addr != '0);
      if (w_grant) begin
        r_wr_addr  <= w_sel_addr;
        r_wr_data  <= w_sel_data;
        r_grant_id <= w_gidx;
      end
    end
  end

  // Arbitration FSM: pointer advance, lock entry, bounded burst and release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= 2'd0;
      r_owner    <= 2'd0;
      r_lock_cnt <= '0;
    end else if (!wr_stall) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_rr_ptr <= w_gidx + 2'd1;
            if (req_lock[w_gidx] && (LOCK_MAX > 1)) begin
              r_state    <= ST_LOCKED;
              r_owner    <= w_gidx;
              r_lock_cnt <= CNT_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (req_valid[r_owner]) begin
            if (!req_lock[r_owner] || (r_lock_cnt == CNT_W'(LOCK_MAX - 1))) begin
              r_state    <= ST_IDLE;
              r_lock_cnt <= '0;
            end else begin
              r_lock_cnt <= r_lock_cnt + CNT_W'(1);
            end
          end else begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign grant_id = r_grant_id;
  assign locked   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (LOCK_MAX = 4).
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_lock;
  logic [4:0]  req_addr0, req_addr1, req_addr2, req_addr3;
  logic [31:0] req_data0, req_data1, req_data2, req_data3;
  logic [3:0]  req_ready;
  logic        wr_stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  grant_id;
  logic        locked;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_write_arbiter #(.LOCK_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_addr2 (req_addr2),
    .req_addr3 (req_addr3),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_data3 (req_data3),
    .req_ready (req_ready),
    .wr_stall  (wr_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected addr/data for requester i in the default setup.
  function automatic logic [4:0] exp_addr(input int i);
    return 5'(i + 4);
  endfunction
  function automatic logic [31:0] exp_data(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  logic [3:0] exp_rdy3 [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010};
  logic       exp_lck3 [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [1:0] exp_gid3 [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};

  initial begin
    int lock_cycles;
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
    wr_stall  = 1'b0;
    req_addr0 = exp_addr(0); req_data0 = exp_data(0);
    req_addr1 = exp_addr(1); req_data1 = exp_data(1);
    req_addr2 = exp_addr(2); req_data2 = exp_data(2);
    req_addr3 = exp_addr(3); req_data3 = exp_data(3);

    // Reset state, including ready held low with requests pending.
    #3;
    req_valid = 4'b1111;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    tick();
    reset = 1'b0;

    // 1: all requesters valid -> 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t1_ready%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      check($sformatf("t1_wr_en%0d", k), 32'(wr_en), 32'h1);
      check($sformatf("t1_gid%0d", k), 32'(grant_id), 32'(k % 4));
      check($sformatf("t1_addr%0d", k), 32'(wr_addr), 32'(exp_addr(k % 4)));
      check($sformatf("t1_data%0d", k), wr_data, exp_data(k % 4));
    end

    // 2: move rr_ptr to 3, then 0110 wraps to 1, then 2.
    req_valid = 4'b0100;
    #1; check("t2_pre_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0110;
    #1; check("t2_ready_a", 32'(req_ready), 32'h2);
    tick();
    check("t2_gid_a", 32'(grant_id), 32'h1);
    #1; check("t2_ready_b", 32'(req_ready), 32'h4);
    tick();
    check("t2_gid_b", 32'(grant_id), 32'h2);

    // No valid requester: no grant, no write.
    req_valid = 4'b0000;
    #1; check("idle_ready", 32'(req_ready), 32'h0);
    tick();
    check("idle_wr_en", 32'(wr_en), 32'h0);

    // 3: put rr_ptr at 1 via one ALU grant, then FPU lock burst with ALU valid.
    req_valid = 4'b0001;
    #1; check("t3_pre_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0011;
    req_lock  = 4'b0010;
    lock_cycles = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("t3_ready%0d", k), 32'(req_ready), 32'(exp_rdy3[k]));
      tick();
      check($sformatf("t3_gid%0d", k), 32'(grant_id), 32'(exp_gid3[k]));
      check($sformatf("t3_locked%0d", k), 32'(locked), 32'(exp_lck3[k]));
      if (k < 5 && locked) lock_cycles++;
    end
    check("t3_lock_len", 32'(lock_cycles), 32'd3);
    // Owner drops request while locked: no grant, lock released.
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
    #1; check("t3_drop_ready", 32'(req_ready), 32'h0);
    tick();
    check("t3_drop_locked", 32'(locked), 32'h0);
    check("t3_drop_wr_en", 32'(wr_en), 32'h0);

    // 4: write to $zero is accepted but not enabled.
    req_valid = 4'b0100;
    req_addr2 = 5'd0;
    req_data2 = 32'hDEAD_BEEF;
    #1; check("t4_ready", 32'(req_ready), 32'h4);
    tick();
    check("t4_wr_en", 32'(wr_en), 32'h0);
    check("t4_data", wr_data, 32'hDEAD_BEEF);
    check("t4_gid", 32'(grant_id), 32'h2);
    check("t4_addr", 32'(wr_addr), 32'h0);
    req_addr2 = exp_addr(2);
    req_data2 = exp_data(2);

    // 5: stall blocks grants for 3 cycles, then grant 0 on release.
    req_valid = 4'b0001;
    wr_stall  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1; check($sformatf("t5_ready%0d", k), 32'(req_ready), 32'h0);
      tick();
      check($sformatf("t5_wr_en%0d", k), 32'(wr_en), 32'h0);
    end
    wr_stall = 1'b0;
    #1; check("t5_rel_ready", 32'(req_ready), 32'h1);
    tick();
    check("t5_rel_wr_en", 32'(wr_en), 32'h1);
    check("t5_rel_gid", 32'(grant_id), 32'h0);

    // 6: enter LOCKED on FPU, stall holds the lock, then async reset mid-burst.
    req_valid = 4'b0010;
    req_lock  = 4'b0010;
    #1; check("t6_ready_a", 32'(req_ready), 32'h2);
    tick();
    check("t6_locked_a", 32'(locked), 32'h1);
    wr_stall = 1'b1;
    #1; check("t6_stall_ready", 32'(req_ready), 32'h0);
    tick();
    check("t6_stall_locked", 32'(locked), 32'h1);
    check("t6_stall_wr_en", 32'(wr_en), 32'h0);
    wr_stall = 1'b0;
    #1; check("t6_ready_b", 32'(req_ready), 32'h2);
    tick();
    check("t6_locked_b", 32'(locked), 32'h1);
    check("t6_wr_en_b", 32'(wr_en), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_wr_en", 32'(wr_en), 32'h0);
    check("t6_rst_addr", 32'(wr_addr), 32'h0);
    check("t6_rst_data", wr_data, 32'h0);
    check("t6_rst_gid", 32'(grant_id), 32'h0);
    check("t6_rst_locked", 32'(locked), 32'h0);
    check("t6_rst_ready", 32'(req_ready), 32'h0);
    tick();
    reset     = 1'b0;
    req_valid = 4'b1010;
    req_lock  = 4'b0000;
    #1; check("t6_post_ready", 32'(req_ready), 32'h2);
    tick();
    check("t6_post_wr_en", 32'(wr_en), 32'h1);
    check("t6_post_gid", 32'(grant_id), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
